// File: rtl/boid_display_sequencer.sv
// Frame refresh sequencer for the boid display RAM: clear, wait for the clear,
// then sweep the boid read index with the display write enable asserted.
module boid_display_sequencer #(
  parameter int unsigned MAX_BOIDS      = 128,
  parameter int unsigned BITS_FOR_BOIDS = 7,
  parameter int unsigned REFRESH_PERIOD = 2097152
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                mode,
  input  logic                      pause,
  input  logic                      screen_end,
  input  logic [BITS_FOR_BOIDS:0]   num_boids,
  input  logic                      clear_busy,
  output logic                      clear_pulse,
  output logic                      disp_we,
  output logic [BITS_FOR_BOIDS-1:0] boid_sel,
  output logic                      busy,
  output logic                      frame_done,
  output logic [7:0]                overrun_count
);

  localparam int unsigned NW = BITS_FOR_BOIDS + 1;
  localparam int unsigned SW = BITS_FOR_BOIDS;
  localparam int unsigned TW = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_PERIOD - 1);
  localparam logic [NW-1:0] N_MAX      = NW'(MAX_BOIDS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    WAIT_CLR = 3'd2,
    SWEEP    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic            se_q;
  logic [NW-1:0]   n_q, n_n;
  logic            clear_pulse_n, disp_we_n, busy_n, frame_done_n;
  logic [SW-1:0]   boid_sel_n;
  logic [7:0]      overrun_n;
  logic            trigger;
  logic            last_sel;

  // Refresh source: screen_end rising edge or free-running timer wrap.
  always_comb begin
    trigger = 1'b0;
    timer_n = '0;
    if (mode == 2'd0) begin
      trigger = screen_end && !se_q;
    end else if (mode == 2'd1) begin
      trigger = (timer == TIMER_LAST);
      timer_n = (timer == TIMER_LAST) ? '0 : timer + TW'(1);
    end
  end

  assign last_sel = ({1'b0, boid_sel} == (n_q - NW'(1)));

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state;
    n_n           = n_q;
    clear_pulse_n = 1'b0;
    disp_we_n     = 1'b0;
    frame_done_n  = 1'b0;
    boid_sel_n    = boid_sel;
    overrun_n     = overrun_count;

    if (trigger && (state != IDLE) && (overrun_count != 8'hFF)) begin
      overrun_n = overrun_count + 8'd1;
    end

    case (state)
      IDLE: begin
        if (trigger && !pause) begin
          state_n       = CLEAR;
          n_n           = (num_boids > N_MAX) ? N_MAX : num_boids;
          clear_pulse_n = 1'b1;
          boid_sel_n    = '0;
        end
      end
      CLEAR: begin
        state_n = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!clear_busy) begin
          if (n_q != '0) begin
            state_n    = SWEEP;
            disp_we_n  = 1'b1;
            boid_sel_n = '0;
          end else begin
            state_n      = DONE;
            frame_done_n = 1'b1;
          end
        end
      end
      SWEEP: begin
        if (last_sel) begin
          state_n      = DONE;
          frame_done_n = 1'b1;
          boid_sel_n   = '0;
        end else begin
          disp_we_n  = 1'b1;
          boid_sel_n = boid_sel + SW'(1);
        end
      end
      DONE: begin
        state_n    = IDLE;
        boid_sel_n = '0;
      end
      default: begin
        state_n    = IDLE;
        boid_sel_n = '0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      se_q          <= 1'b0;
      n_q           <= '0;
      clear_pulse   <= 1'b0;
      disp_we       <= 1'b0;
      boid_sel      <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      overrun_count <= '0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      se_q          <= screen_end;
      n_q           <= n_n;
      clear_pulse   <= clear_pulse_n;
      disp_we       <= disp_we_n;
      boid_sel      <= boid_sel_n;
      busy          <= busy_n;
      frame_done    <= frame_done_n;
      overrun_count <= overrun_n;
    end
  end

endmodule

// File: tb/tb_boid_display_sequencer.sv
// Scoreboard bench for boid_display_sequencer: expected output events are queued
// by the stimulus and matched by a negedge monitor (kind, index and cycle).
module tb_boid_display_sequencer;

  localparam int K_CLR  = 0;
  localparam int K_WE   = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       pause;
  logic       screen_end;
  logic [7:0] num_boids;
  logic       clear_busy;
  logic       clear_pulse;
  logic       disp_we;
  logic [6:0] boid_sel;
  logic       busy;
  logic       frame_done;
  logic [7:0] overrun_count;

  ev_t exp_q[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  boid_display_sequencer #(
    .MAX_BOIDS     (128),
    .BITS_FOR_BOIDS(7),
    .REFRESH_PERIOD(16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode),
    .pause        (pause),
    .screen_end   (screen_end),
    .num_boids    (num_boids),
    .clear_busy   (clear_busy),
    .clear_pulse  (clear_pulse),
    .disp_we      (disp_we),
    .boid_sel     (boid_sel),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun_count(overrun_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic push_ev(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Sweep of n indices starting at cycle w, followed by frame_done.
  task automatic push_sweep(input int w, input int n);
    for (int k = 0; k < n; k++) push_ev(K_WE, k, w + k);
    push_ev(K_DONE, 0, w + n);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_ev(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: actual kind=%0d val=%0d cyc=%0d required none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: actual kind=%0d val=%0d cyc=%0d required kind=%0d val=%0d cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
    chk("busy_with_event", int'(busy), 1);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (clear_pulse) check_ev(K_CLR, 0);
      if (disp_we)     check_ev(K_WE, int'(boid_sel));
      if (frame_done)  check_ev(K_DONE, 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One-cycle screen_end pulse; optionally queue the accepted frame.
  task automatic fire(input bit accept, input int n, input bit sweep_now, output int t);
    t = cyc + 1;
    if (accept) begin
      push_ev(K_CLR, 0, t);
      if (sweep_now) push_sweep(t + 2, n);
    end
    screen_end = 1'b1;
    @(negedge clock);
    screen_end = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int k0;
    reset      = 1'b1;
    mode       = 2'd0;
    pause      = 1'b0;
    screen_end = 1'b0;
    num_boids  = 8'd4;
    clear_busy = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("rst_clear_pulse", int'(clear_pulse), 0);
    chk("rst_disp_we", int'(disp_we), 0);
    chk("rst_boid_sel", int'(boid_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun_count), 0);

    // Basic four-boid frame.
    fire(1'b1, 4, 1'b1, t);
    idle(8);
    chk("n4_busy_after", int'(busy), 0);
    chk("n4_overrun", int'(overrun_count), 0);

    // Clear held busy for 10 cycles; 200 clamps to 128; mid-frame num_boids ignored.
    num_boids  = 8'd200;
    clear_busy = 1'b1;
    fire(1'b1, 128, 1'b0, t);
    num_boids = 8'd5;
    idle(10);
    clear_busy = 1'b0;
    push_sweep(cyc + 1, 128);
    idle(135);
    chk("clamp_busy_after", int'(busy), 0);

    // Zero boids.
    num_boids = 8'd0;
    fire(1'b1, 0, 1'b1, t);
    idle(6);
    chk("n0_busy_after", int'(busy), 0);

    // Timer mode, period 16.
    num_boids = 8'd2;
    k0 = cyc;
    for (int i = 1; i <= 4; i++) begin
      push_ev(K_CLR, 0, k0 + 16 * i);
      push_sweep(k0 + 16 * i + 2, 2);
    end
    mode = 2'd1;
    idle(66);
    mode = 2'd0;
    idle(6);
    chk("timer_busy_after", int'(busy), 0);

    // Three overruns during a full sweep.
    num_boids = 8'd128;
    fire(1'b1, 128, 1'b1, t);
    idle(10);
    for (int i = 0; i < 3; i++) begin
      fire(1'b0, 0, 1'b0, t);
      idle(1);
    end
    idle(140);
    chk("overrun_3", int'(overrun_count), 3);

    // Pause in IDLE: ignored and not counted.
    pause = 1'b1;
    fire(1'b0, 0, 1'b0, t);
    idle(5);
    chk("pause_overrun", int'(overrun_count), 3);
    chk("pause_busy", int'(busy), 0);
    pause = 1'b0;

    // Hold mode: no trigger.
    mode = 2'd2;
    fire(1'b0, 0, 1'b0, t);
    idle(3);
    chk("hold_overrun", int'(overrun_count), 3);
    chk("hold_busy", int'(busy), 0);
    mode = 2'd0;

    // Stall in WAIT_CLR and pile up overruns to saturation (pause does not mask them).
    num_boids  = 8'd3;
    clear_busy = 1'b1;
    fire(1'b1, 3, 1'b0, t);
    idle(1);
    for (int i = 0; i < 200; i++) begin
      fire(1'b0, 0, 1'b0, t);
      idle(1);
    end
    chk("overrun_203", int'(overrun_count), 203);
    pause = 1'b1;
    for (int i = 0; i < 100; i++) begin
      fire(1'b0, 0, 1'b0, t);
      idle(1);
    end
    chk("overrun_sat", int'(overrun_count), 255);
    pause      = 1'b0;
    clear_busy = 1'b0;
    push_sweep(cyc + 1, 3);
    idle(8);
    chk("stall_busy_after", int'(busy), 0);

    // Asynchronous reset at sweep index 50.
    num_boids = 8'd128;
    fire(1'b1, 128, 1'b0, t);
    for (int k = 0; k <= 50; k++) push_ev(K_WE, k, t + 2 + k);
    idle(52);
    #1 reset = 1'b1;
    #1;
    chk("arst_disp_we", int'(disp_we), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_boid_sel", int'(boid_sel), 0);
    chk("arst_overrun", int'(overrun_count), 0);
    chk("arst_frame_done", int'(frame_done), 0);
    idle(2);
    reset = 1'b0;
    idle(1);
    fire(1'b1, 128, 1'b1, t);
    idle(135);
    chk("post_rst_busy", int'(busy), 0);

    // Trigger on the DONE->IDLE edge is an overrun.
    num_boids = 8'd1;
    fire(1'b1, 1, 1'b1, t);
    idle(3);
    fire(1'b0, 0, 1'b0, t);
    idle(5);
    chk("done_edge_overrun", int'(overrun_count), 1);
    chk("done_edge_busy", int'(busy), 0);

    // screen_end held high gives a single trigger.
    t = cyc + 1;
    push_ev(K_CLR, 0, t);
    push_sweep(t + 2, 1);
    screen_end = 1'b1;
    idle(12);
    screen_end = 1'b0;
    idle(3);
    chk("held_overrun", int'(overrun_count), 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
